// File: rtl/fifo_rd_stream_adapter_if.sv
// Handshake bundle between the FIFO read port, the adapter and the stream sink.
interface fifo_rd_stream_adapter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_re_o;
  logic                  fifo_rrdy_i;
  logic [DATA_WIDTH-1:0] fifo_dout_i;
  logic                  flush_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic [1:0]            level_o;

  modport master (
    output fifo_re_o, m_valid_o, m_data_o, level_o,
    input  fifo_rrdy_i, fifo_dout_i, flush_i, m_ready_i
  );

  modport slave (
    input  fifo_re_o, m_valid_o, m_data_o, level_o,
    output fifo_rrdy_i, fifo_dout_i, flush_i, m_ready_i
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-port to FWFT valid/ready stream; 2-entry buffer with credit-based
// read issue so a word read from the FIFO always has a slot to land in.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  fifo_rd_stream_adapter_if.master   bus
);

  logic [1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic                       head_q, head_d;
  logic                       tail_q, tail_d;
  logic [1:0]                 occ_q, occ_d;
  logic                       inflight_q;
  logic                       m_valid;
  logic                       pop, push, credit, re_core;

  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid & bus.m_ready_i;
  assign push    = inflight_q & ~bus.flush_i;

  // A slot is free if stored + in-flight words leave room, or a pop frees one this edge.
  assign credit  = (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2) | pop;
  assign re_core = bus.fifo_rrdy_i & ~bus.flush_i & credit;

  // Reset gates the read enable combinationally; the flop path uses re_core
  // since it only samples outside reset.
  assign bus.fifo_re_o = re_core & rst_ni;
  assign bus.m_valid_o = m_valid;
  assign bus.m_data_o  = buf_q[head_q];
  assign bus.level_o   = occ_q;

  always_comb begin
    buf_d  = buf_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push) begin
      buf_d[tail_q] = bus.fifo_dout_i;
      tail_d        = ~tail_q;
    end
    if (pop) head_d = ~head_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    // A pop in the flush cycle still completes; everything else is discarded.
    if (bus.flush_i) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      occ_d  = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q      <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= re_core;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench: emulated FIFO read port, queue-based model of the buffered words,
// per-cycle output compare plus directed literal expectations.
module tb_fifo_rd_stream_adapter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_rd_stream_adapter_if #(.DATA_WIDTH(8)) bus ();

  fifo_rd_stream_adapter #(.DATA_WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  // Emulated FIFO: words written by stimulus, read when re & rrdy at an edge.
  logic [7:0] mem [512];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic       rrdy_en;
  assign bus.fifo_rrdy_i = rrdy_en && (wr_cnt != rd_cnt);

  // Model: words held by the adapter, in order, plus whether a word is in flight.
  logic [7:0] bm [$];
  bit         infl_m = 1'b0;
  bit         rst_s, re_s, pop_s, flush_s;
  logic [7:0] dout_s;

  logic [7:0] hs_d [$];
  int         hs_c [$];
  int         re_cnt = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic chk_hs(input string n, input int i, input int exp);
    if (i < hs_d.size()) chk(n, int'(hs_d[i]), exp);
    else                 chk(n, -1, exp);
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_cnt] = w;
    wr_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hs_clear();
    hs_d.delete();
    hs_c.delete();
  endtask

  // Per-cycle compare against the model, then sample what the next edge will see.
  always @(negedge clk) begin
    bit exp_re;
    if (!rst_n) begin
      chk("rst_valid", int'(bus.m_valid_o), 0);
      chk("rst_level", int'(bus.level_o), 0);
      chk("rst_re",    int'(bus.fifo_re_o), 0);
      bm.delete();
      infl_m = 1'b0;
    end else begin
      exp_re = bus.fifo_rrdy_i && !bus.flush_i &&
               (((bm.size() + int'(infl_m)) < 2) || (bm.size() != 0 && bus.m_ready_i));
      chk("re",    int'(bus.fifo_re_o), int'(exp_re));
      chk("valid", int'(bus.m_valid_o), int'(bm.size() != 0));
      chk("level", int'(bus.level_o), bm.size());
      if (bm.size() != 0) chk("data", int'(bus.m_data_o), int'(bm[0]));
      if (bus.m_valid_o && bus.m_ready_i) begin
        hs_d.push_back(bus.m_data_o);
        hs_c.push_back(cyc);
      end
      if (bus.fifo_re_o && bus.fifo_rrdy_i) re_cnt++;
    end
    rst_s   = rst_n;
    re_s    = bus.fifo_re_o && bus.fifo_rrdy_i && rst_n;
    pop_s   = bus.m_valid_o && bus.m_ready_i && rst_n;
    flush_s = bus.flush_i;
    dout_s  = bus.fifo_dout_i;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_s) begin
      if (pop_s && bm.size() != 0) void'(bm.pop_front());
      if (infl_m && !flush_s) begin
        chk("overflow", int'(bm.size() < 2), 1);
        bm.push_back(dout_s);
      end
      if (flush_s) bm.delete();
      infl_m = re_s;
    end
    #1;
    if (re_s) begin
      bus.fifo_dout_i = mem[rd_cnt];
      rd_cnt++;
    end
  end

  initial begin
    int c0, r;
    rst_n           = 1'b1;
    rrdy_en         = 1'b1;
    bus.m_ready_i   = 1'b0;
    bus.flush_i     = 1'b0;
    bus.fifo_dout_i = 8'h00;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("reset_valid", int'(bus.m_valid_o), 0);
    chk("reset_data",  int'(bus.m_data_o), 0);
    chk("reset_level", int'(bus.level_o), 0);
    rst_n = 1'b1;
    tick();

    // Basic: three words, sink always ready.
    bus.m_ready_i = 1'b1;
    tick();
    hs_clear();
    c0 = cyc;
    push(8'h11); push(8'h22); push(8'h33);
    repeat (6) tick();
    chk("t1_count", hs_d.size(), 3);
    chk_hs("t1_w0", 0, 'h11);
    chk_hs("t1_w1", 1, 'h22);
    chk_hs("t1_w2", 2, 'h33);
    if (hs_c.size() == 3) begin
      chk("t1_latency", hs_c[0] - c0, 2);
      chk("t1_back2back", hs_c[2] - hs_c[0], 2);
    end else chk("t1_latency", -1, 2);
    chk("t1_level", int'(bus.level_o), 0);

    // Backpressure: only two reads while the sink stalls.
    bus.m_ready_i = 1'b0;
    hs_clear();
    re_cnt = 0;
    push(8'h40); push(8'h41); push(8'h42); push(8'h43);
    repeat (10) tick();
    chk("t2_reads", re_cnt, 2);
    chk("t2_level", int'(bus.level_o), 2);
    chk("t2_hold",  int'(bus.m_data_o), 'h40);
    bus.m_ready_i = 1'b1;
    repeat (8) tick();
    chk("t2_count", hs_d.size(), 4);
    for (int i = 0; i < 4; i++) chk_hs("t2_order", i, 'h40 + i);

    // Streaming 16 words through pointer wrap.
    hs_clear();
    for (int i = 0; i < 16; i++) push(8'(i));
    repeat (22) tick();
    chk("t3_count", hs_d.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk_hs("t3_data", i, i);
      if (i < hs_c.size()) chk("t3_consec", hs_c[i] - hs_c[0], i);
    end

    // Random sink ready and FIFO availability.
    hs_clear();
    for (int i = 0; i < 100; i++) push(8'(i));
    for (int k = 0; k < 1500 && hs_d.size() < 100; k++) begin
      bus.m_ready_i = 1'($urandom % 2);
      rrdy_en       = (($urandom % 4) != 0);
      tick();
    end
    bus.m_ready_i = 1'b1;
    rrdy_en       = 1'b1;
    repeat (4) tick();
    chk("t4_count", hs_d.size(), 100);
    for (int i = 0; i < 100; i++) chk_hs("t4_seq", i, i);

    // Flush with one stored, one in flight, while the sink takes the head.
    bus.m_ready_i = 1'b0;
    hs_clear();
    push(8'h50); push(8'h51);
    tick(); tick();
    chk("t5_pre_level", int'(bus.level_o), 1);
    bus.flush_i   = 1'b1;
    bus.m_ready_i = 1'b1;
    tick();
    bus.flush_i   = 1'b0;
    bus.m_ready_i = 1'b0;
    #1;
    chk("t5_level", int'(bus.level_o), 0);
    chk("t5_valid", int'(bus.m_valid_o), 0);
    push(8'hA5);
    bus.m_ready_i = 1'b1;
    repeat (5) tick();
    chk("t5_count", hs_d.size(), 2);
    chk_hs("t5_handoff", 0, 'h50);
    chk_hs("t5_first", 1, 'hA5);

    // Flush with a full buffer; the word still in the FIFO comes out next.
    bus.m_ready_i = 1'b0;
    hs_clear();
    push(8'h70); push(8'h71); push(8'h72);
    repeat (4) tick();
    chk("t5b_level", int'(bus.level_o), 2);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("t5b_level0", int'(bus.level_o), 0);
    bus.m_ready_i = 1'b1;
    repeat (5) tick();
    chk("t5b_count", hs_d.size(), 1);
    chk_hs("t5b_first", 0, 'h72);

    // Asynchronous reset mid-stream.
    hs_clear();
    push(8'h60); push(8'h61); push(8'h62); push(8'h63); push(8'h64); push(8'h65);
    repeat (3) tick();
    chk("t6_pre_level", int'(bus.level_o), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(bus.m_valid_o), 0);
    chk("t6_level", int'(bus.level_o), 0);
    chk("t6_data",  int'(bus.m_data_o), 0);
    chk("t6_re",    int'(bus.fifo_re_o), 0);
    tick(); tick();
    rst_n = 1'b1;
    r = cyc;
    repeat (8) tick();
    chk("t6_count", hs_d.size(), 4);
    chk_hs("t6_before", 0, 'h60);
    chk_hs("t6_after",  1, 'h63);
    chk_hs("t6_last",   3, 'h65);
    if (hs_c.size() > 1) chk("t6_latency", hs_c[1] - r, 2);
    else                 chk("t6_latency", -1, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
